// File: rtl/tile_feed_sequencer.sv
// tile_feed_sequencer: issues one A/B operand read-beat stream per tile, then waits out skew + PE drain.
// Optional perf counters are enabled by defining TILE_FEED_SEQ_PERF_EN.
`default_nettype none

module tile_feed_sequencer #(
    parameter int DRAIN_CYC = 16,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [3:0]        cfg_type_i,   // {datatype[1:0], rc[1:0]}
    input  logic [7:0]        k_beats_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic              stall_i,
    input  logic              abort_i,
    output logic              en_o,
    output logic              cmen_o,
    output logic [ADDR_W-1:0] rdaddr_a_o,
    output logic [ADDR_W-1:0] rdaddr_b_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
`ifdef TILE_FEED_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt_o,
    output logic [15:0]       perf_tile_cnt_o
`endif
);

    localparam logic [1:0] DT_INT8 = 2'd0;
    localparam logic [1:0] DT_FP16 = 2'd1;
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [8:0]        idx_q, idx_d;
    logic [8:0]        nb_q, nb_d;
    logic              half_a_q, half_a_d, half_b_q, half_b_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
    logic [7:0]        drain_q, drain_d;
    logic              en_q, en_d, cmen_q, cmen_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] rda_q, rda_d, rdb_q, rdb_d;

    logic [1:0]        dt, rc;
    logic [8:0]        nbeats;
    logic              half_a, half_b;
    logic [ADDR_W-1:0] off_a, off_b;

    assign dt     = cfg_type_i[3:2];
    assign rc     = cfg_type_i[1:0];
    assign nbeats = (k_beats_i == 8'd0) ? 9'd256 : {1'b0, k_beats_i};
    assign half_a = (dt == DT_FP16) || (dt == DT_INT8 && (rc == 2'b01 || rc == 2'b10));
    assign half_b = (dt == DT_FP16 && (rc == 2'b01 || rc == 2'b10)) ||
                    (dt == DT_INT8 && (rc == 2'b00 || rc == 2'b01));
    assign off_a  = half_a_q ? ADDR_W'({idx_q, 1'b0}) : ADDR_W'({idx_q, 2'b00});
    assign off_b  = half_b_q ? ADDR_W'({idx_q, 1'b0}) : ADDR_W'({idx_q, 2'b00});

    // Beat 0 is issued on the accepting edge so en follows start by one cycle;
    // the FEED state then issues beats 1..n-1. A single-beat tile goes straight to DRAIN.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nb_d     = nb_q;
        half_a_d = half_a_q;
        half_b_d = half_b_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        drain_d  = drain_q;
        en_d     = 1'b0;
        cmen_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rda_d    = rda_q;
        rdb_d    = rdb_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (rc == 2'b11) begin
                            err_d = 1'b1;
                        end else begin
                            nb_d     = nbeats;
                            half_a_d = half_a;
                            half_b_d = half_b;
                            base_a_d = base_a_i;
                            base_b_d = base_b_i;
                            idx_d    = 9'd1;
                            en_d     = 1'b1;
                            cmen_d   = (nbeats == 9'd1);
                            rda_d    = base_a_i;
                            rdb_d    = base_b_i;
                            drain_d  = DRAIN_INIT;
                            state_d  = (nbeats == 9'd1) ? S_DRAIN : S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    if (!stall_i) begin
                        en_d   = 1'b1;
                        rda_d  = base_a_q + off_a;
                        rdb_d  = base_b_q + off_b;
                        cmen_d = (idx_q == nb_q - 9'd1);
                        idx_d  = idx_q + 9'd1;
                        if (idx_q == nb_q - 9'd1) begin
                            drain_d = DRAIN_INIT;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        drain_d = drain_q - 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            nb_q     <= '0;
            half_a_q <= 1'b0;
            half_b_q <= 1'b0;
            base_a_q <= '0;
            base_b_q <= '0;
            drain_q  <= '0;
            en_q     <= 1'b0;
            cmen_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rda_q    <= '0;
            rdb_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nb_q     <= nb_d;
            half_a_q <= half_a_d;
            half_b_q <= half_b_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            drain_q  <= drain_d;
            en_q     <= en_d;
            cmen_q   <= cmen_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rda_q    <= rda_d;
            rdb_q    <= rdb_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign en_o       = en_q;
    assign cmen_o     = cmen_q;
    assign rdaddr_a_o = rda_q;
    assign rdaddr_b_o = rdb_q;
    assign done_o     = done_q;
    assign cfg_err_o  = err_q;

`ifdef TILE_FEED_SEQ_PERF_EN
    logic [15:0] perf_stall_q, perf_tile_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_tile_q  <= '0;
        end else begin
            if (state_q == S_FEED && stall_i && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
            if (done_q && perf_tile_q != 16'hFFFF)
                perf_tile_q <= perf_tile_q + 16'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_tile_cnt_o  = perf_tile_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tile_feed_sequencer.sv
// Directed bench for tile_feed_sequencer: table of tile configs plus stall/abort/reset/256-beat sequences.
`default_nettype none

module tb_tile_feed_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0, stall_i = 1'b0, abort_i = 1'b0;
    logic [3:0] cfg_type_i = '0;
    logic [7:0] k_beats_i = '0, base_a_i = '0, base_b_i = '0;
    logic       ready_o, en_o, cmen_o, busy_o, done_o, cfg_err_o;
    logic [7:0] rdaddr_a_o, rdaddr_b_o;
`ifdef TILE_FEED_SEQ_PERF_EN
    logic [15:0] perf_stall_cnt_o, perf_tile_cnt_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    tile_feed_sequencer #(.DRAIN_CYC(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .cfg_type_i (cfg_type_i),
        .k_beats_i  (k_beats_i),
        .base_a_i   (base_a_i),
        .base_b_i   (base_b_i),
        .stall_i    (stall_i),
        .abort_i    (abort_i),
        .en_o       (en_o),
        .cmen_o     (cmen_o),
        .rdaddr_a_o (rdaddr_a_o),
        .rdaddr_b_o (rdaddr_b_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o)
`ifdef TILE_FEED_SEQ_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_tile_cnt_o  (perf_tile_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      dt;
        logic [1:0]      rc;
        logic [7:0]      k;
        logic [7:0]      ba;
        logic [7:0]      bb;
        logic [3:0][7:0] ea;
        logic [3:0][7:0] eb;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [1:0] dt, input logic [1:0] rc, input logic [7:0] k,
                              input logic [7:0] ba, input logic [7:0] bb);
        cfg_type_i = {dt, rc};
        k_beats_i  = k;
        base_a_i   = ba;
        base_b_i   = bb;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    // Called in the cycle showing the last beat; done is due 16 cycles later.
    task automatic wait_done(input string nm);
        int c;
        c = 1;
        step();
        chk({nm, " en after last"}, {31'd0, en_o}, 32'd0);
        while (!done_o && c < 40) begin
            step();
            c++;
        end
        chk({nm, " done latency"}, c, 32'd16);
        chk({nm, " ready with done"}, {31'd0, ready_o}, 32'd1);
    endtask

    task automatic run_vec(input int i);
        int k;
        k = int'(tbl[i].k);
        start_tile(tbl[i].dt, tbl[i].rc, tbl[i].k, tbl[i].ba, tbl[i].bb);
        for (int b = 0; b < k; b++) begin
            chk($sformatf("v%0d b%0d en", i, b), {31'd0, en_o}, 32'd1);
            chk($sformatf("v%0d b%0d rda", i, b), {24'd0, rdaddr_a_o}, {24'd0, tbl[i].ea[b]});
            chk($sformatf("v%0d b%0d rdb", i, b), {24'd0, rdaddr_b_o}, {24'd0, tbl[i].eb[b]});
            chk($sformatf("v%0d b%0d cmen", i, b), {31'd0, cmen_o}, {31'd0, (b == k - 1)});
            if (b < k - 1) step();
        end
        wait_done($sformatf("v%0d", i));
    endtask

    // INT8 rc=10: A stride 2, B stride 4; ns bubble cycles before beat 2.
    task automatic feed_with_stalls(input int ns);
        start_tile(2'd0, 2'b10, 8'd3, 8'h00, 8'h00);
        chk("st b0 a", {24'd0, rdaddr_a_o}, 32'h00);
        step();
        chk("st b1 en", {31'd0, en_o}, 32'd1);
        chk("st b1 a", {24'd0, rdaddr_a_o}, 32'h02);
        chk("st b1 b", {24'd0, rdaddr_b_o}, 32'h04);
        stall_i = 1'b1;
        for (int s = 0; s < ns; s++) begin
            step();
            if (s == ns - 1) stall_i = 1'b0;
            chk("st bubble en", {31'd0, en_o}, 32'd0);
            chk("st bubble cmen", {31'd0, cmen_o}, 32'd0);
            chk("st bubble a hold", {24'd0, rdaddr_a_o}, 32'h02);
            chk("st bubble b hold", {24'd0, rdaddr_b_o}, 32'h04);
        end
        step();
        chk("st b2 en", {31'd0, en_o}, 32'd1);
        chk("st b2 a", {24'd0, rdaddr_a_o}, 32'h04);
        chk("st b2 b", {24'd0, rdaddr_b_o}, 32'h08);
        chk("st b2 cmen", {31'd0, cmen_o}, 32'd1);
        wait_done("st");
    endtask

    initial begin
        int seen;
        int beats;
        int last_idx;
        logic [7:0] last_a;

        // dt: 0=INT8 1=FP16 2=INT4 3=other
        tbl[0] = '{2'd1, 2'b00, 8'd4, 8'h10, 8'h40, {8'h16, 8'h14, 8'h12, 8'h10}, {8'h4C, 8'h48, 8'h44, 8'h40}};
        tbl[1] = '{2'd0, 2'b01, 8'd2, 8'h20, 8'h30, {8'h00, 8'h00, 8'h22, 8'h20}, {8'h00, 8'h00, 8'h32, 8'h30}};
        tbl[2] = '{2'd2, 2'b00, 8'd3, 8'hFC, 8'h00, {8'h00, 8'h04, 8'h00, 8'hFC}, {8'h00, 8'h08, 8'h04, 8'h00}};
        tbl[3] = '{2'd1, 2'b10, 8'd1, 8'h05, 8'h07, {8'h00, 8'h00, 8'h00, 8'h05}, {8'h00, 8'h00, 8'h00, 8'h07}};
        tbl[4] = '{2'd0, 2'b00, 8'd3, 8'h00, 8'hFE, {8'h00, 8'h08, 8'h04, 8'h00}, {8'h00, 8'h02, 8'h00, 8'hFE}};
        tbl[5] = '{2'd3, 2'b01, 8'd2, 8'h80, 8'h81, {8'h00, 8'h00, 8'h84, 8'h80}, {8'h00, 8'h00, 8'h85, 8'h81}};

        repeat (3) step();
        chk("rst ready", {31'd0, ready_o}, 32'd1);
        chk("rst en", {31'd0, en_o}, 32'd0);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst addr", {16'd0, rdaddr_a_o, rdaddr_b_o}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        feed_with_stalls(1);

        // rc=11 rejected
        start_tile(2'd1, 2'b11, 8'd2, 8'h00, 8'h00);
        chk("err pulse", {31'd0, cfg_err_o}, 32'd1);
        chk("err ready", {31'd0, ready_o}, 32'd1);
        chk("err en", {31'd0, en_o}, 32'd0);
        step();
        chk("err one cycle", {31'd0, cfg_err_o}, 32'd0);
        chk("err still idle", {31'd0, busy_o}, 32'd0);

        // abort with start in IDLE
        abort_i = 1'b1;
        start_tile(2'd1, 2'b00, 8'd2, 8'h00, 8'h00);
        abort_i = 1'b0;
        chk("abort+start en", {31'd0, en_o}, 32'd0);
        chk("abort+start ready", {31'd0, ready_o}, 32'd1);

        // abort on 2nd FEED cycle
        start_tile(2'd1, 2'b00, 8'd4, 8'h10, 8'h40);
        step();
        chk("ab b1 a", {24'd0, rdaddr_a_o}, 32'h12);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("ab en", {31'd0, en_o}, 32'd0);
        chk("ab ready", {31'd0, ready_o}, 32'd1);
        chk("ab busy", {31'd0, busy_o}, 32'd0);
        seen = 0;
        repeat (20) begin
            step();
            if (done_o) seen++;
        end
        chk("ab no done", seen, 32'd0);
        run_vec(0);

        // k_beats=0 -> 256 beats, cmen on beat 255
        start_tile(2'd2, 2'b00, 8'd0, 8'h00, 8'h00);
        beats = 0;
        last_idx = -1;
        last_a = 8'h00;
        for (int c = 0; c < 300 && last_idx < 0; c++) begin
            if (en_o) begin
                if (cmen_o) begin
                    last_idx = beats;
                    last_a = rdaddr_a_o;
                end
                beats++;
            end
            if (last_idx < 0) step();
        end
        chk("k0 cmen index", last_idx, 32'd255);
        chk("k0 last addr", {24'd0, last_a}, 32'hFC);
        wait_done("k0");

        // async reset mid-DRAIN
        start_tile(2'd1, 2'b00, 8'd2, 8'h10, 8'h40);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("arst ready", {31'd0, ready_o}, 32'd1);
        chk("arst busy", {31'd0, busy_o}, 32'd0);
        chk("arst addr", {16'd0, rdaddr_a_o, rdaddr_b_o}, 32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            step();
            if (done_o) seen++;
        end
        chk("arst no done", seen, 32'd0);

`ifdef TILE_FEED_SEQ_PERF_EN
        chk("perf reset", {perf_stall_cnt_o, perf_tile_cnt_o}, 32'd0);
        feed_with_stalls(1);
        feed_with_stalls(2);
        step();
        chk("perf tiles", {16'd0, perf_tile_cnt_o}, 32'd2);
        chk("perf stalls", {16'd0, perf_stall_cnt_o}, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
